// File: rtl/sevenseg_scan_decoder_pkg.sv
// Shared definitions for the seven-segment scan decoder: active-low glyph
// patterns, FSM state encoding, anode select patterns and small helpers.
package sevenseg_scan_decoder_pkg;

  // Active-low segment patterns, seg[0]=a ... seg[6]=g
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Scan FSM states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  // Active-low anode patterns selecting exactly one digit
  localparam logic [3:0] AN_DIGIT0 = 4'b1110;
  localparam logic [3:0] AN_DIGIT1 = 4'b1101;
  localparam logic [3:0] AN_DIGIT2 = 4'b1011;
  localparam logic [3:0] AN_DIGIT3 = 4'b0111;

  // Decoded view of one segment pattern
  typedef struct packed {
    logic [3:0] value;
    logic       is_blank;
    logic       is_known;
  } glyph_t;

  // True when exactly one anode line is driven low
  function automatic logic an_is_single(input logic [3:0] an_v);
    logic single;
    case (an_v)
      AN_DIGIT0, AN_DIGIT1, AN_DIGIT2, AN_DIGIT3: single = 1'b1;
      default:                                    single = 1'b0;
    endcase
    return single;
  endfunction

  // Digit index of a single-low anode pattern
  function automatic logic [1:0] an_index(input logic [3:0] an_v);
    logic [1:0] idx;
    case (an_v)
      AN_DIGIT1: idx = 2'd1;
      AN_DIGIT2: idx = 2'd2;
      AN_DIGIT3: idx = 2'd3;
      default:   idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/sevenseg_scan_decoder_glyph_decode.sv
// Combinational map from an active-low segment pattern to a hex value,
// flagging the all-off pattern and anything that is not a known glyph.
module sevenseg_glyph_decode
  import sevenseg_scan_decoder_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] value,
  output logic       is_blank,
  output logic       is_known
);

  // Table lookup; blank reads as F so the caller can store it directly
  always_comb begin
    value    = 4'h0;
    is_blank = 1'b0;
    is_known = 1'b1;
    case (seg)
      SEG_0: value = 4'h0;
      SEG_1: value = 4'h1;
      SEG_2: value = 4'h2;
      SEG_3: value = 4'h3;
      SEG_4: value = 4'h4;
      SEG_5: value = 4'h5;
      SEG_6: value = 4'h6;
      SEG_7: value = 4'h7;
      SEG_8: value = 4'h8;
      SEG_9: value = 4'h9;
      SEG_A: value = 4'hA;
      SEG_B: value = 4'hB;
      SEG_C: value = 4'hC;
      SEG_D: value = 4'hD;
      SEG_E: value = 4'hE;
      SEG_F: value = 4'hF;
      SEG_BLANK: begin
        value    = 4'hF;
        is_blank = 1'b1;
        is_known = 1'b0;
      end
      default: is_known = 1'b0;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Recovers the four displayed hex digits from the multiplexed active-low
// anode/segment scan lines. A digit is captured once its anode pattern and
// segments have been stable long enough; per-digit valid/blank/stale flags
// and frame/error pulses accompany the captured values.
module sevenseg_scan_decoder
  import sevenseg_scan_decoder_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] an,
  input  logic [6:0] seg,
  output logic [3:0] d3,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic [3:0] dvalid,
  output logic [3:0] blank,
  output logic [3:0] stale,
  output logic       frame_done,
  output logic       decode_err
);

  localparam int SCW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]  TIMEOUT_V   = TW'(TIMEOUT_CYCLES);

  logic [3:0]     an_meta_q, an_meta_d, an_sync_q, an_sync_d;
  logic [6:0]     seg_meta_q, seg_meta_d, seg_sync_q, seg_sync_d;
  logic [1:0]     state_q, state_d;
  logic [3:0]     an_lock_q, an_lock_d;
  logic [6:0]     seg_lock_q, seg_lock_d;
  logic [SCW-1:0] settle_cnt_q, settle_cnt_d;
  logic           capture;
  logic [3:0]     digit_q [4];
  logic [3:0]     digit_d [4];
  logic [3:0]     dvalid_q, dvalid_d, blank_q, blank_d, stale_q, stale_d;
  logic [TW-1:0]  stale_cnt_q [4];
  logic [TW-1:0]  stale_cnt_d [4];
  logic [3:0]     seen_q, seen_d, seen_set;
  logic           frame_done_q, frame_done_d, decode_err_q, decode_err_d;
  logic [1:0]     cap_idx;
  glyph_t         glyph;

  // Two-stage synchronizer inputs for the asynchronous scan lines
  always_comb begin
    an_meta_d  = an;
    an_sync_d  = an_meta_q;
    seg_meta_d = seg;
    seg_sync_d = seg_meta_q;
  end

  sevenseg_glyph_decode u_glyph_decode (
    .seg      (seg_lock_q),
    .value    (glyph.value),
    .is_blank (glyph.is_blank),
    .is_known (glyph.is_known)
  );

  // Scan FSM: lock onto a single-low anode, wait for stable segments, capture once
  always_comb begin
    state_d      = state_q;
    an_lock_d    = an_lock_q;
    seg_lock_d   = seg_lock_q;
    settle_cnt_d = settle_cnt_q;
    capture      = 1'b0;
    if (state_q == ST_IDLE || an_sync_q != an_lock_q) begin
      if (an_is_single(an_sync_q)) begin
        state_d      = ST_SETTLE;
        an_lock_d    = an_sync_q;
        seg_lock_d   = seg_sync_q;
        settle_cnt_d = '0;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (state_q == ST_SETTLE) begin
      if (seg_sync_q != seg_lock_q) begin
        seg_lock_d   = seg_sync_q;
        settle_cnt_d = '0;
      end else if (settle_cnt_q == SETTLE_LAST) begin
        capture = 1'b1;
        state_d = ST_HOLD;
      end else begin
        settle_cnt_d = settle_cnt_q + SCW'(1);
      end
    end else if (state_q != ST_HOLD) begin
      state_d = ST_IDLE;
    end
  end

  assign cap_idx = an_index(an_lock_q);

  // Capture bookkeeping: digit values, flags, stale timers and frame mask
  always_comb begin
    dvalid_d     = dvalid_q;
    blank_d      = blank_q;
    seen_d       = seen_q;
    seen_set     = seen_q;
    frame_done_d = 1'b0;
    decode_err_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      digit_d[i]     = digit_q[i];
      stale_cnt_d[i] = (stale_cnt_q[i] == TIMEOUT_V) ? stale_cnt_q[i]
                                                     : stale_cnt_q[i] + TW'(1);
    end
    if (capture) begin
      if (glyph.is_known || glyph.is_blank) begin
        digit_d[cap_idx]     = glyph.value;
        dvalid_d[cap_idx]    = 1'b1;
        blank_d[cap_idx]     = glyph.is_blank;
        stale_cnt_d[cap_idx] = '0;
        seen_set             = seen_q | (4'b0001 << cap_idx);
        if (seen_set == 4'hF) begin
          frame_done_d = 1'b1;
          seen_d       = 4'h0;
        end else begin
          seen_d = seen_set;
        end
      end else begin
        decode_err_d = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      stale_d[i] = (stale_cnt_d[i] == TIMEOUT_V);
    end
  end

  // State registers with synchronous reset; idle scan lines reset to all-off
  always_ff @(posedge clk) begin
    if (rst) begin
      an_meta_q    <= 4'hF;
      an_sync_q    <= 4'hF;
      seg_meta_q   <= SEG_BLANK;
      seg_sync_q   <= SEG_BLANK;
      state_q      <= ST_IDLE;
      an_lock_q    <= 4'hF;
      seg_lock_q   <= SEG_BLANK;
      settle_cnt_q <= '0;
      dvalid_q     <= '0;
      blank_q      <= '0;
      stale_q      <= '0;
      seen_q       <= '0;
      frame_done_q <= 1'b0;
      decode_err_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        digit_q[i]     <= '0;
        stale_cnt_q[i] <= '0;
      end
    end else begin
      an_meta_q    <= an_meta_d;
      an_sync_q    <= an_sync_d;
      seg_meta_q   <= seg_meta_d;
      seg_sync_q   <= seg_sync_d;
      state_q      <= state_d;
      an_lock_q    <= an_lock_d;
      seg_lock_q   <= seg_lock_d;
      settle_cnt_q <= settle_cnt_d;
      dvalid_q     <= dvalid_d;
      blank_q      <= blank_d;
      stale_q      <= stale_d;
      seen_q       <= seen_d;
      frame_done_q <= frame_done_d;
      decode_err_q <= decode_err_d;
      for (int i = 0; i < 4; i++) begin
        digit_q[i]     <= digit_d[i];
        stale_cnt_q[i] <= stale_cnt_d[i];
      end
    end
  end

  assign d0         = digit_q[0];
  assign d1         = digit_q[1];
  assign d2         = digit_q[2];
  assign d3         = digit_q[3];
  assign dvalid     = dvalid_q;
  assign blank      = blank_q;
  assign stale      = stale_q;
  assign frame_done = frame_done_q;
  assign decode_err = decode_err_q;

endmodule
